if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_pkg.sv | 24 ++
 rtl/if_skid_fifo.sv | 85 ++++++++
 rtl/if_stage.sv | 151 +++++++++++++++
 tb/tb_if_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared definitions for the instruction-fetch stage.
//   NOP_INSTR        - canonical NOP returned with a misaligned-redirect trap
//   FIFO_DEPTH       - number of {pc, instr} entries buffered ahead of decode
//   DEFAULT_RESET_PC - default first fetch address after reset
//   fetch_state_e    - RUN / TRAP / HALT fetch control states
//   fetch_entry_t    - one buffered fetch result
package if_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned FIFO_DEPTH       = 2;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_skid_fifo.sv
// if_skid_fifo: 2-entry {pc, instr} buffer between instruction memory and decode.
// Entry 0 is always the head, so the head payload comes straight from a flop.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   push       - write push_data this cycle (accepted when not full, or full with pop)
//   pop        - drop the head this cycle (ignored when empty)
//   flush      - discard all entries; wins over push and pop
//   push_data  - entry to write
//   full/empty - occupancy flags
//   head       - oldest entry (zero after reset)
module if_skid_fifo
  import if_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_s, push_s;

  assign full  = (cnt_q == 2'(FIFO_DEPTH));
  assign empty = (cnt_q == 2'd0);
  assign head  = e0_q;

  // Next-state for the entry registers and the occupancy count.
  always_comb begin
    e0_d   = e0_q;
    e1_d   = e1_q;
    cnt_d  = cnt_q;
    pop_s  = pop & ~empty;
    push_s = push & (~full | pop_s);
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            e0_d = push_data;
          end else begin
            e1_d = push_data;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: occupancy unchanged, new entry lands behind the survivor.
          if (cnt_q == 2'd1) begin
            e0_d = push_data;
          end else begin
            e0_d = e1_q;
            e1_d = push_data;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Entry and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a 2-deep credit window and redirect flush.
// Optional feature macro: IF_MISALIGN_TRAP_EN (trap on misaligned redirect
// targets; when undefined, redirect_pc[1:0] is ignored and out_misalign is 0).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   imem_rd_addr    - fetch byte address (redirect target overrides pc_q)
//   imem_rd_data    - instruction word, one cycle after its address
//   redirect_valid  - branch/jump/trap redirect request
//   redirect_pc     - redirect target
//   out_valid/ready - decode handshake
//   out_pc/instr    - delivered instruction and its address
//   out_misalign    - misaligned-redirect exception flag
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_rd_addr,
  input  logic [31:0] imem_rd_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign
);

  logic [31:0]  pc_q, pc_d, rsp_pc_q, rsp_pc_d, trap_pc_q, trap_pc_d;
  logic         in_flight_q, in_flight_d;
  fetch_state_e state_q, state_d;
  logic [31:0]  redir_pc_s;
  logic         redir_misalign_s;
  logic         push_s, pop_s, flush_s, issue_s, credit_s;
  logic         fifo_full_s, fifo_empty_s;
  logic [2:0]   fifo_count_s, occupancy_s;
  fetch_entry_t head_s, push_data_s;

`ifdef IF_MISALIGN_TRAP_EN
  assign redir_pc_s       = redirect_pc;
  assign redir_misalign_s = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc_s       = {redirect_pc[31:2], 2'b00};
  assign redir_misalign_s = 1'b0;
`endif

  assign imem_rd_addr = redirect_valid ? redir_pc_s : pc_q;
  assign push_data_s  = '{pc: rsp_pc_q, instr: imem_rd_data};
  assign fifo_count_s = fifo_full_s ? 3'd2 : (fifo_empty_s ? 3'd0 : 3'd1);

  if_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .flush     (flush_s),
    .push_data (push_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (head_s)
  );

  // Fetch control: redirect handling, credit-based issue, FSM next state and outputs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    trap_pc_d    = trap_pc_q;
    issue_s      = 1'b0;
    flush_s      = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    occupancy_s  = 3'd0;
    credit_s     = 1'b0;
    out_valid    = 1'b0;
    out_misalign = 1'b0;
    out_pc       = head_s.pc;
    out_instr    = head_s.instr;
    if (redirect_valid) begin
      // Redirect beats any pop or response write; in-flight data is dropped by not pushing it.
      flush_s = 1'b1;
      if (redir_misalign_s) begin
        state_d   = ST_TRAP;
        trap_pc_d = redirect_pc;
      end else begin
        state_d = ST_RUN;
        issue_s = 1'b1;
        pc_d    = redir_pc_s + 32'd4;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          out_valid   = ~fifo_empty_s;
          pop_s       = ~fifo_empty_s & out_ready;
          push_s      = in_flight_q;
          // Never let buffered plus outstanding fetches exceed the FIFO depth.
          occupancy_s = {2'b00, in_flight_q} + fifo_count_s - {2'b00, pop_s};
          credit_s    = (occupancy_s < 3'(FIFO_DEPTH));
          if (credit_s) begin
            issue_s = 1'b1;
            pc_d    = pc_q + 32'd4;
          end else begin
            issue_s = 1'b0;
          end
        end
        ST_TRAP: begin
          out_valid    = 1'b1;
          out_misalign = 1'b1;
          out_pc       = trap_pc_q;
          out_instr    = NOP_INSTR;
          if (out_ready) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_TRAP;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
    in_flight_d = issue_s;
    if (issue_s) begin
      rsp_pc_d = imem_rd_addr;
    end else begin
      rsp_pc_d = rsp_pc_q;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= 32'd0;
      trap_pc_q   <= 32'd0;
      in_flight_q <= 1'b0;
      state_q     <= ST_RUN;
    end else begin
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      trap_pc_q   <= trap_pc_d;
      in_flight_q <= in_flight_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and random checks of if_stage against a stream model.
// The model tracks only the architectural expectation: the next PC decode
// should see, whether a trap report or silence is due, and payload hold.
module tb_if_stage;
  import if_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef IF_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_rd_addr, imem_rd_data, redirect_pc, out_pc, out_instr;
  logic        redirect_valid, out_valid, out_ready, out_misalign;
  logic [31:0] mem_addr_q;

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] exp_pc, trap_pc, hold_pc, hold_instr;
  int          mode;  // 0 stream, 1 trap report due, 2 silent
  logic        hold_v;
  // samples of the last run_cycle
  logic        s_valid, s_mis;
  logic [31:0] s_pc, s_instr, s_addr;
  int          accepts;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rd_addr   (imem_rd_addr),
    .imem_rd_data   (imem_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misalign   (out_misalign)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: synchronous read, data one cycle after the address.
  always @(posedge clk) mem_addr_q <= imem_rd_addr;
  assign imem_rd_data = instr_of(mem_addr_q);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = RST_PC;
    mode   = 0;
    hold_v = 1'b0;
  endtask

  // Apply inputs just after a falling edge, sample mid-cycle, update model, wait next falling edge.
  task automatic run_cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic [31:0] aligned;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    s_valid = out_valid; s_pc = out_pc; s_instr = out_instr;
    s_mis = out_misalign; s_addr = imem_rd_addr;
    aligned = {rpc[31:2], 2'b00};
    if (hold_v && !rv) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_pc", out_pc, hold_pc);
      chk("hold_instr", out_instr, hold_instr);
    end
    if (rv) begin
      chk("redir_valid_low", {31'd0, out_valid}, 32'd0);
      chk("redir_addr", imem_rd_addr, TRAP_EN ? rpc : aligned);
      if (TRAP_EN && (rpc[1:0] != 2'b00)) begin
        mode    = 1;
        trap_pc = rpc;
      end else begin
        mode   = 0;
        exp_pc = aligned;
      end
      hold_v = 1'b0;
    end else begin
      case (mode)
        1: begin
          chk("trap_valid", {31'd0, out_valid}, 32'd1);
          chk("trap_mis", {31'd0, out_misalign}, 32'd1);
          chk("trap_pc", out_pc, trap_pc);
          chk("trap_instr", out_instr, NOP_INSTR);
          if (out_valid && rdy) mode = 2;
        end
        2: begin
          chk("halt_silent", {31'd0, out_valid}, 32'd0);
        end
        default: begin
          chk("stream_mis", {31'd0, out_misalign}, 32'd0);
          if (out_valid) begin
            chk("stream_pc", out_pc, exp_pc);
            chk("stream_instr", out_instr, instr_of(exp_pc));
            if (rdy) begin
              exp_pc = exp_pc + 32'd4;
              accepts++;
            end
          end
        end
      endcase
      hold_v     = out_valid && !rdy;
      hold_pc    = out_pc;
      hold_instr = out_instr;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] stall_addr, rpc;
    logic        rv, rdy;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
    accepts = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mis", {31'd0, out_misalign}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", imem_rd_addr, RST_PC);
    @(negedge clk);
    rst = 1'b0;

    // reset release: 0, 4, 8 back-to-back, two cycles after first issue
    run_cycle(1'b0, 32'd0, 1'b1); chk("first_issue", s_addr, RST_PC);
    run_cycle(1'b0, 32'd0, 1'b1); chk("lat_gap", {31'd0, s_valid}, 32'd0);
    run_cycle(1'b0, 32'd0, 1'b1); chk("first_out_pc", s_pc, 32'h0);
    chk("first_out_v", {31'd0, s_valid}, 32'd1);
    run_cycle(1'b0, 32'd0, 1'b1); chk("second_out_pc", s_pc, 32'h4);
    run_cycle(1'b0, 32'd0, 1'b1); chk("third_out_pc", s_pc, 32'h8);

    // 5-cycle stall: no further issue, head held
    stall_addr = 32'd0;
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b0, 32'd0, 1'b0);
      if (i == 0) stall_addr = s_addr;
      else chk("stall_no_issue", s_addr, stall_addr);
    end
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 32'd0, 1'b1);
      chk("resume_stream", {31'd0, s_valid}, 32'd1);
    end

    // redirect with a full FIFO
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 32'd0, 1'b0);
    run_cycle(1'b1, 32'h100, 1'b0);
    run_cycle(1'b0, 32'd0, 1'b1); chk("redir_gap", {31'd0, s_valid}, 32'd0);
    run_cycle(1'b0, 32'd0, 1'b1); chk("redir_pc0", s_pc, 32'h100);
    chk("redir_v0", {31'd0, s_valid}, 32'd1);
    run_cycle(1'b0, 32'd0, 1'b1); chk("redir_pc1", s_pc, 32'h104);

    // wrap-around
    run_cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    run_cycle(1'b0, 32'd0, 1'b1);
    run_cycle(1'b0, 32'd0, 1'b1); chk("wrap_pc0", s_pc, 32'hFFFF_FFFC);
    run_cycle(1'b0, 32'd0, 1'b1); chk("wrap_pc1", s_pc, 32'h0000_0000);

    // misaligned redirect
    run_cycle(1'b1, 32'h102, 1'b1);
`ifdef IF_MISALIGN_TRAP_EN
    run_cycle(1'b0, 32'd0, 1'b1);
    chk("mis_valid", {31'd0, s_valid}, 32'd1);
    chk("mis_flag", {31'd0, s_mis}, 32'd1);
    chk("mis_pc", s_pc, 32'h102);
    chk("mis_instr", s_instr, 32'h13);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 32'd0, 1'b1);
      chk("mis_silence", {31'd0, s_valid}, 32'd0);
    end
`else
    chk("mis_aligned_addr", s_addr, 32'h100);
    run_cycle(1'b0, 32'd0, 1'b1);
    run_cycle(1'b0, 32'd0, 1'b1); chk("mis_off_pc0", s_pc, 32'h100);
    chk("mis_off_flag", {31'd0, s_mis}, 32'd0);
    run_cycle(1'b0, 32'd0, 1'b1); chk("mis_off_pc1", s_pc, 32'h104);
`endif

    // random traffic
    run_cycle(1'b1, 32'h200, 1'b1);
    accepts = 0;
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 99) < 4);
      rdy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom() & 32'hFFFF_FFFC;
        1:       rpc = 32'hFFFF_FFF8;
        2:       rpc = $urandom();
        default: rpc = 32'h0000_0040;
      endcase
      run_cycle(rv, rpc, rdy);
    end
    chk("random_progress", {31'd0, (accepts >= 50)}, 32'd1);

    // reset during a stall with two buffered entries
    run_cycle(1'b1, 32'h300, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 32'd0, 1'b0);
    chk("pre_rst_valid", {31'd0, s_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    chk("arst_mis", {31'd0, out_misalign}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_cycle(1'b0, 32'd0, 1'b1); chk("refetch_addr", s_addr, RST_PC);
    run_cycle(1'b0, 32'd0, 1'b1); chk("refetch_gap", {31'd0, s_valid}, 32'd0);
    run_cycle(1'b0, 32'd0, 1'b1); chk("refetch_pc0", s_pc, RST_PC);
    chk("refetch_v0", {31'd0, s_valid}, 32'd1);
    run_cycle(1'b0, 32'd0, 1'b1); chk("refetch_pc1", s_pc, RST_PC + 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
